// File: rtl/mem_burst_sequencer.sv
// Burst writer for a dual-port memory: slices a wide word onto port A,
// optionally reads it back on port B and tallies compare failures.
module mem_burst_sequencer #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int WORDS        = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              trigger,
    input  logic                              verify,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic [WORDS*DATA_WIDTH-1:0]       wide_data,
    output logic [ADDR_WIDTH-1:0]             a_addr,
    output logic [DATA_WIDTH-1:0]             a_wdata,
    output logic                              a_we,
    output logic [ADDR_WIDTH-1:0]             b_addr,
    output logic                              b_en,
    input  logic [DATA_WIDTH-1:0]             b_rdata,
    output logic                              busy,
    output logic                              done,
    output logic                              mismatch,
    output logic [$clog2(WORDS+1)-1:0]        mismatch_count,
    output logic [ADDR_WIDTH-1:0]             first_bad_addr,
    output logic                              overrun
);

    localparam int CW = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST   = CW'(WORDS - 1);
    localparam logic [CW-1:0] NWORDS = CW'(WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic                          trig_q;
    logic [WORDS*DATA_WIDTH-1:0]   data_q;
    logic [ADDR_WIDTH-1:0]         base_q;
    logic                          verify_q;
    logic [CW-1:0]                 wi_q, wi_d;
    logic [CW-1:0]                 rj_q, rj_d;
    logic                          vld_q [READ_LATENCY];
    logic [CW-1:0]                 idx_q [READ_LATENCY];
    logic                          mism_q;
    logic [CW-1:0]                 cnt_q;
    logic [ADDR_WIDTH-1:0]         fba_q;
    logic                          ovr_q;

    logic                          rise;
    logic                          issue;
    logic                          cmp_vld;
    logic [CW-1:0]                 cmp_idx;
    logic                          cmp_bad;

    assign rise    = trigger & ~trig_q;
    assign issue   = (state_q == S_VERIFY) && (rj_q != NWORDS);
    assign cmp_vld = vld_q[READ_LATENCY-1];
    assign cmp_idx = idx_q[READ_LATENCY-1];
    assign cmp_bad = cmp_vld &&
        (b_rdata != data_q[int'(cmp_idx)*DATA_WIDTH +: DATA_WIDTH]);

    always_comb begin
        state_d = state_q;
        wi_d    = wi_q;
        rj_d    = rj_q;
        a_we    = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        b_en    = 1'b0;
        b_addr  = '0;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_WRITE;
                    wi_d    = '0;
                    rj_d    = '0;
                end
            end
            S_WRITE: begin
                a_we    = 1'b1;
                a_addr  = base_q + ADDR_WIDTH'(wi_q);
                a_wdata = data_q[int'(wi_q)*DATA_WIDTH +: DATA_WIDTH];
                if (wi_q == LAST) begin
                    state_d = verify_q ? S_VERIFY : S_DONE;
                end else begin
                    wi_d = wi_q + CW'(1);
                end
            end
            S_VERIFY: begin
                if (issue) begin
                    b_en   = 1'b1;
                    b_addr = base_q + ADDR_WIDTH'(rj_q);
                    rj_d   = rj_q + CW'(1);
                end
                // The last compare retires the burst; reads finished earlier.
                if (cmp_vld && cmp_idx == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            trig_q   <= 1'b1;
            data_q   <= '0;
            base_q   <= '0;
            verify_q <= 1'b0;
            wi_q     <= '0;
            rj_q     <= '0;
            mism_q   <= 1'b0;
            cnt_q    <= '0;
            fba_q    <= '0;
            ovr_q    <= 1'b0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                vld_q[k] <= 1'b0;
                idx_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            trig_q  <= trigger;
            wi_q    <= wi_d;
            rj_q    <= rj_d;
            vld_q[0] <= issue;
            idx_q[0] <= rj_q;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
            if (state_q == S_IDLE && rise) begin
                data_q   <= wide_data;
                base_q   <= base_addr;
                verify_q <= verify;
                mism_q   <= 1'b0;
                cnt_q    <= '0;
                fba_q    <= '0;
            end
            if (state_q != S_IDLE && rise) begin
                ovr_q <= 1'b1;
            end
            if (cmp_bad) begin
                mism_q <= 1'b1;
                if (cnt_q != NWORDS) begin
                    cnt_q <= cnt_q + CW'(1);
                end
                if (!mism_q) begin
                    fba_q <= base_q + ADDR_WIDTH'(cmp_idx);
                end
            end
        end
    end

    assign mismatch       = mism_q;
    assign mismatch_count = cnt_q;
    assign first_bad_addr = fba_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_mem_burst_sequencer.sv
// Directed bench for mem_burst_sequencer with a 1-cycle dual-port
// memory model that can corrupt chosen readback words.
module tb_mem_burst_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         trigger;
    logic         verify;
    logic [15:0]  base_addr;
    logic [127:0] wide_data;
    logic [15:0]  a_addr;
    logic [31:0]  a_wdata;
    logic         a_we;
    logic [15:0]  b_addr;
    logic         b_en;
    logic [31:0]  b_rdata;
    logic         busy;
    logic         done;
    logic         mismatch;
    logic [2:0]   mismatch_count;
    logic [15:0]  first_bad_addr;
    logic         overrun;

    int n_vec = 0;
    int n_bad = 0;

    logic        cor_en;
    logic        cor_all;
    logic [15:0] cor_addr;
    logic [31:0] mem [0:65535];

    always #5 clk = ~clk;

    mem_burst_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .trigger        (trigger),
        .verify         (verify),
        .base_addr      (base_addr),
        .wide_data      (wide_data),
        .a_addr         (a_addr),
        .a_wdata        (a_wdata),
        .a_we           (a_we),
        .b_addr         (b_addr),
        .b_en           (b_en),
        .b_rdata        (b_rdata),
        .busy           (busy),
        .done           (done),
        .mismatch       (mismatch),
        .mismatch_count (mismatch_count),
        .first_bad_addr (first_bad_addr),
        .overrun        (overrun)
    );

    always @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_en) begin
            if (cor_all || (cor_en && b_addr == cor_addr))
                b_rdata <= mem[b_addr] ^ 32'h0000_00FF;
            else
                b_rdata <= mem[b_addr];
        end
    end

    typedef struct {
        logic         verify;
        logic [15:0]  base;
        logic [127:0] data;
        logic         cor_en;
        logic         cor_all;
        logic [15:0]  cor_addr;
        int           done_k;
        logic         mm;
        logic [2:0]   cnt;
        logic [15:0]  fba;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [15:0]  ea;
        logic [127:0] e, a;
        @(negedge clk);
        verify    = v.verify;
        base_addr = v.base;
        wide_data = v.data;
        cor_en    = v.cor_en;
        cor_all   = v.cor_all;
        cor_addr  = v.cor_addr;
        trigger   = 1'b1;
        for (int k = 1; k <= v.done_k + 1; k++) begin
            @(negedge clk);
            trigger = 1'b0;
            e = '0;
            e[67] = (k <= v.done_k);
            e[66] = (k == v.done_k);
            if (k >= 1 && k <= 4) begin
                ea = v.base + 16'(k - 1);
                e[65] = 1'b1;
                e[63:48] = ea;
                e[47:16] = v.data[(k-1)*32 +: 32];
            end
            if (v.verify && k >= 5 && k <= 8) begin
                ea = v.base + 16'(k - 5);
                e[64] = 1'b1;
                e[15:0] = ea;
            end
            a = '0;
            a[67] = busy;
            a[66] = done;
            a[65] = a_we;
            a[64] = b_en;
            if (a_we) begin
                a[63:48] = a_addr;
                a[47:16] = a_wdata;
            end
            if (b_en) a[15:0] = b_addr;
            chk($sformatf("vec%0d cyc%0d", id, k), a, e);
            if (k == v.done_k) begin
                chk($sformatf("vec%0d result", id),
                    {mismatch, mismatch_count, first_bad_addr},
                    {v.mm, v.cnt, v.fba});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int nw;
        vecs[0] = '{1'b0, 16'h0001,
                    128'h4444_4444_3333_3333_2222_2222_1111_1111,
                    1'b0, 1'b0, 16'h0000, 5, 1'b0, 3'd0, 16'h0000};
        vecs[1] = '{1'b1, 16'h0001,
                    128'h4444_4444_3333_3333_2222_2222_1111_1111,
                    1'b0, 1'b0, 16'h0000, 10, 1'b0, 3'd0, 16'h0000};
        vecs[2] = '{1'b1, 16'h0001,
                    128'h4444_4444_3333_3333_2222_2222_1111_1111,
                    1'b1, 1'b0, 16'h0003, 10, 1'b1, 3'd1, 16'h0003};
        vecs[3] = '{1'b1, 16'h0001,
                    128'h4444_4444_3333_3333_2222_2222_1111_1111,
                    1'b0, 1'b0, 16'h0000, 10, 1'b0, 3'd0, 16'h0000};
        vecs[4] = '{1'b0, 16'hFFFE,
                    128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001,
                    1'b0, 1'b0, 16'h0000, 5, 1'b0, 3'd0, 16'h0000};
        vecs[5] = '{1'b1, 16'hFFFE,
                    128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001,
                    1'b1, 1'b0, 16'hFFFF, 10, 1'b1, 3'd1, 16'hFFFF};
        vecs[6] = '{1'b1, 16'h0100,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    1'b0, 1'b1, 16'h0000, 10, 1'b1, 3'd4, 16'h0100};

        reset = 1'b1;
        trigger = 1'b0;
        verify = 1'b0;
        base_addr = '0;
        wide_data = '0;
        cor_en = 1'b0;
        cor_all = 1'b0;
        cor_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs",
            {a_addr, a_wdata, a_we, b_addr, b_en, busy, done,
             mismatch, mismatch_count, first_bad_addr, overrun}, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
        chk("no overrun yet", {127'd0, overrun}, 128'd0);

        // Second rise lands while the first burst is still writing.
        verify = 1'b0;
        base_addr = 16'h0020;
        trigger = 1'b1;
        nw = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            trigger = (k == 2);
            if (a_we) nw++;
        end
        chk("overrun writes", 128'(nw), 128'd4);
        chk("overrun flag", {127'd0, overrun}, 128'd1);
        chk("overrun idle", {127'd0, busy}, 128'd0);

        // Reset in the middle of a burst.
        base_addr = 16'h0040;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midburst reset",
            {a_addr, a_wdata, a_we, b_addr, b_en, busy, done,
             mismatch, mismatch_count, first_bad_addr, overrun}, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("after reset idle", {126'd0, a_we, busy}, 128'd0);
        run_vec(7, vecs[0]);

        // Trigger held high across reset release starts nothing.
        trigger = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        nw = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (a_we || busy) nw++;
        end
        chk("held trigger", 128'(nw), 128'd0);
        trigger = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
